// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller sharing one hex decoder across all digits.
// Double-buffered digit data is swapped into the active set only at frame boundaries.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned BLANK_CYC  = 500
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      upd,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     en_in,
    output logic [3:0]                dec_in,
    input  logic [7:0]                dec_out,
    output logic [7:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     digit_sel,
    output logic                      frame_done,
    output logic                      upd_ack
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  pending_q, pending_d;
    logic [VAL_W-1:0]      shadow_value_q, shadow_value_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0] shadow_en_q, shadow_en_d;
    logic [VAL_W-1:0]      active_value_q, active_value_d;
    logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
    logic [NUM_DIGITS-1:0] active_en_q, active_en_d;
    logic [7:0]            seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic                  frame_done_q, frame_done_d;
    logic                  upd_ack_q, upd_ack_d;

    logic                  slot_wrap_c;
    logic                  last_digit_c;
    logic                  boundary_c;
    logic                  drive_c;
    logic                  sel_en_c;
    logic                  sel_dp_c;

    // Only the seven segment bits of the shared decoder are used.
    logic unused_dec_msb;
    assign unused_dec_msb = dec_out[7];

    // Decoder input follows the current digit for the whole slot so it settles during BLANK.
    always_comb begin
        dec_in = 4'h0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) begin
                dec_in = active_value_q[4*k +: 4];
            end
        end
    end

    // Next-state: scan counters, double buffer and registered display outputs.
    always_comb begin
        slot_cnt_d     = slot_cnt_q;
        idx_d          = idx_q;
        pending_d      = pending_q;
        shadow_value_d = shadow_value_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_en_d    = shadow_en_q;
        active_value_d = active_value_q;
        active_dp_d    = active_dp_q;
        active_en_d    = active_en_q;
        seg_out_d      = 8'h00;
        digit_sel_d    = '0;
        frame_done_d   = 1'b0;
        upd_ack_d      = 1'b0;
        sel_en_c       = 1'b0;
        sel_dp_c       = 1'b0;

        slot_wrap_c  = (slot_cnt_q == CNT_W'(SCAN_DIV - 1));
        last_digit_c = (idx_q == IDX_W'(NUM_DIGITS - 1));
        boundary_c   = slot_wrap_c && last_digit_c;

        if (slot_wrap_c) begin
            slot_cnt_d = '0;
            idx_d      = last_digit_c ? '0 : idx_q + IDX_W'(1);
        end else begin
            slot_cnt_d = slot_cnt_q + CNT_W'(1);
        end

        // Old shadow moves to active before a same-cycle upd overwrites the shadow.
        if (boundary_c && pending_q) begin
            active_value_d = shadow_value_q;
            active_dp_d    = shadow_dp_q;
            active_en_d    = shadow_en_q;
        end
        if (upd) begin
            shadow_value_d = value_in;
            shadow_dp_d    = dp_in;
            shadow_en_d    = en_in;
        end
        pending_d    = upd | (pending_q & ~boundary_c);
        frame_done_d = boundary_c;
        upd_ack_d    = boundary_c & pending_q;

        // DRIVE implies no slot change this edge, so dec_out already matches idx_d.
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_d == IDX_W'(k)) begin
                sel_en_c = active_en_q[k];
                sel_dp_c = active_dp_q[k];
            end
        end
        drive_c = (slot_cnt_d >= CNT_W'(BLANK_CYC));
        if (drive_c && sel_en_c) begin
            digit_sel_d = NUM_DIGITS'(1) << idx_d;
            seg_out_d   = {sel_dp_c, dec_out[6:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_q     <= '0;
            idx_q          <= '0;
            pending_q      <= 1'b0;
            shadow_value_q <= '0;
            shadow_dp_q    <= '0;
            shadow_en_q    <= '0;
            active_value_q <= '0;
            active_dp_q    <= '0;
            active_en_q    <= '0;
            seg_out_q      <= 8'h00;
            digit_sel_q    <= '0;
            frame_done_q   <= 1'b0;
            upd_ack_q      <= 1'b0;
        end else begin
            slot_cnt_q     <= slot_cnt_d;
            idx_q          <= idx_d;
            pending_q      <= pending_d;
            shadow_value_q <= shadow_value_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_en_q    <= shadow_en_d;
            active_value_q <= active_value_d;
            active_dp_q    <= active_dp_d;
            active_en_q    <= active_en_d;
            seg_out_q      <= seg_out_d;
            digit_sel_q    <= digit_sel_d;
            frame_done_q   <= frame_done_d;
            upd_ack_q      <= upd_ack_d;
        end
    end

    assign seg_out    = seg_out_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;
    assign upd_ack    = upd_ack_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Multiplexed scan controller for a multi-digit 7-segment display that shares one hex-to-segment decoder instance across all digits. Each digit gets a fixed time slot. In each slot the controller drives the digit's nibble into the shared decoder, blanks outputs while the decoder settles, then drives the decoded segments and the one-hot digit select. A double-buffered update path prevents tearing mid-frame. Sits between the application logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 50000, clock cycles per digit slot (>= BLANK_CYC+2)
BLANK_CYC, 500, cycles at slot start with all outputs blanked (>= 1, anti-ghosting)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
upd  in  1  one-cycle strobe; capture value_in/dp_in/en_in into shadow
value_in  in  4*NUM_DIGITS  nibble per digit; digit k = bits [4k+3:4k]
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
en_in  in  NUM_DIGITS  digit enable per digit, 0 = blank
dec_in  out  4  nibble to shared decoder (combinational from active regs and idx)
dec_out  in  8  segment pattern from shared decoder, active-high, bit7 ignored
seg_out  out  8  registered; [6:0] segments, [7] decimal point, active-high
digit_sel  out  NUM_DIGITS  registered, one-hot active-high digit drive
frame_done  out  1  one-cycle pulse at end of each full frame
upd_ack  out  1  one-cycle pulse when shadow is transferred to active

Behaviour:
- Counters: slot_cnt 0..SCAN_DIV-1, wraps; idx 0..NUM_DIGITS-1 increments on slot_cnt wrap and wraps to 0 after NUM_DIGITS-1.
- Slot phases: BLANK while slot_cnt < BLANK_CYC, DRIVE otherwise. Outputs are registered from the next-state count, so the registered values are aligned with the current slot_cnt and phase.
- BLANK: digit_sel = 0, seg_out = 0.
- DRIVE with active_en[idx]=1: digit_sel = 1<<idx, seg_out = {active_dp[idx], dec_out[6:0]}.
- DRIVE with active_en[idx]=0: digit_sel = 0, seg_out = 0. The slot time is still consumed, so brightness stays uniform.
- dec_in = active_value[idx] for the whole slot, including BLANK, so the decoder settles before DRIVE.
- Frame boundary is the cycle with idx = NUM_DIGITS-1 and slot_cnt = SCAN_DIV-1. frame_done pulses 1 cycle after the boundary edge.
- Update path:
  - upd=1 loads the shadow registers and sets pending.
  - On the boundary edge with pending=1: shadow copies to active, and upd_ack pulses in the following cycle together with frame_done.
  - pending_next = upd | (pending & ~boundary).
  - upd on the boundary cycle: the old shadow (if pending) transfers, the new data is captured into shadow, and pending stays 1, so it applies at the next frame.
  - Multiple upd in one frame: last one wins; only one upd_ack is issued.
- Reset (rst_n=0 at edge), which also aborts any scan in progress:
  - slot_cnt=0, idx=0, pending=0.
  - Shadow and active value/dp/en = 0.
  - seg_out=0, digit_sel=0, frame_done=0, upd_ack=0.
  - After release, scanning restarts at digit 0 in BLANK, with all digits disabled until the first transfer.
- digit_sel is never multi-hot. Outputs never change except on clk edges.

Test Plan:
(Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2; bench decoder model: 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66.)
1. Reset: assert rst_n low for 3 cycles mid-slot, then release -> all outputs 0 during reset; idx restarts at 0; digit_sel stays 0 for the whole first frame; frame_done first pulses 32 cycles after release.
2. upd with value_in=16'h1234, en_in=4'hF, dp_in=4'b0010 in frame 0 -> upd_ack at end of frame 0. In frame 1:
   - each slot: digit_sel=0 for 2 cycles, then active for 6 cycles.
   - digit 0: dec_in=4, seg_out=0x66, digit_sel=0001.
   - digit 1: dec_in=3, seg_out=0xCF, digit_sel=0010.
   - digit 2: seg_out=0x5B.
   - digit 3: seg_out=0x06.
3. Timing: frame_done pulse period exactly 32 cycles; each pulse exactly 1 cycle wide; digit_sel never multi-hot (assertion over 10 frames).
4. en_in=4'b0101 -> in slots 1 and 3, digit_sel=0 and seg_out=0 for all 8 cycles; slots 0 and 2 display normally; frame length stays 32.
5. Two upd strobes in one frame (values 16'h1111 then 16'h2222) -> exactly one upd_ack; next frame shows only 2s (seg_out=0x5B); no partial frame shows 1s.
6. upd with 16'hAAAA on the boundary cycle while pending holds 16'h5555 -> the next frame shows 5s and upd_ack pulses; the frame after shows As and upd_ack pulses again.
